// File: rtl/display_scan_ctrl_pkg.sv
// display_pkg: shared constants, scan state type and packed-BCD slicing
// helper for the display scan controller.
package display_pkg;

  localparam int BCD_W      = 4;
  localparam int BCD_MAX    = 9;
  // Widest display the slicing helper accepts; callers zero-extend into it.
  localparam int MAX_DIGITS = 16;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  // Returns digit i of a packed BCD word (digit i at bits [4i+3:4i]).
  function automatic logic [BCD_W-1:0] digit_of(
    input logic [BCD_W*MAX_DIGITS-1:0] data,
    input int                          i
  );
    return data[BCD_W*i +: BCD_W];
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if: valid/ready load port carrying a packed BCD value.
//   load_valid  producer -> controller, value offered
//   load_ready  controller -> producer, pending slot empty
//   load_data   producer -> controller, packed BCD, digit i at [4i+3:4i]
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import display_pkg::*;

  logic                        load_valid;
  logic                        load_ready;
  logic [BCD_W*NUM_DIGITS-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);

endinterface

// File: rtl/display_scan_ctrl_scan_timer.sv
// scan_timer: slot counter (0..REFRESH_DIV-1) and digit index
// (0..NUM_DIGITS-1) with the GUARD/DRIVE slot state.
//   clk, rst    clock, async active-high reset
//   idx         current digit index
//   frame_wrap  last cycle of the last slot of a frame
//   in_guard    current cycle lies in the anti-ghosting guard window
module scan_timer
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 64,
  parameter int CNT_W        = $clog2(REFRESH_DIV),
  parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx,
  output logic             frame_wrap,
  output logic             in_guard
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  scan_state_e      state_q, state_d;
  logic             slot_wrap;

  always_comb begin
    slot_wrap  = (cnt_q == CNT_LAST);
    frame_wrap = slot_wrap && (idx_q == IDX_LAST);
    cnt_d      = slot_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    // Explicit compare so non-power-of-two digit counts wrap correctly.
    if (slot_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    state_d = state_q;
    case (state_q)
      GUARD:   if (cnt_q == GUARD_LAST) state_d = DRIVE;
      DRIVE:   if (slot_wrap) state_d = GUARD;
      default: state_d = GUARD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= GUARD;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  assign idx      = idx_q;
  assign in_guard = (state_q == GUARD);

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed scan controller for a shared
// BCD-to-7-segment decoder.
//   clk, rst    clock, async active-high reset
//   ld          slave load port; accepted values are applied at frame
//               boundaries only
//   lz_en       leading-zero blanking enable
//   bcd_out     {D,C,B,A} code to the decoder
//   digit_en    one-hot digit select, all zero during the guard window
//   seg_blank   forces decoder segments off
//   frame_done  one-cycle pulse after the last slot of a frame
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  display_scan_ctrl_if.slave    ld,
  input  logic                  lz_en,
  output logic [BCD_W-1:0]      bcd_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  seg_blank,
  output logic                  frame_done
);

  localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int               DATA_W   = BCD_W * NUM_DIGITS;
  localparam logic [BCD_W-1:0] BCD_LIM  = BCD_W'(BCD_MAX);

  logic [IDX_W-1:0] idx;
  logic             frame_wrap;
  logic             in_guard;

  scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .IDX_W       (IDX_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .idx       (idx),
    .frame_wrap(frame_wrap),
    .in_guard  (in_guard)
  );

  logic [DATA_W-1:0]           active_q, active_d;
  logic [DATA_W-1:0]           pending_q, pending_d;
  logic                        pend_full_q, pend_full_d;
  logic                        load_ready_q, load_ready_d;
  logic [BCD_W-1:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]       digit_en_q, digit_en_d;
  logic                        seg_blank_q, seg_blank_d;
  logic                        frame_done_q, frame_done_d;

  logic                        accept;
  logic [BCD_W*MAX_DIGITS-1:0] active_ext;
  logic [BCD_W-1:0]            cur_dig;
  logic                        upper_zero;
  logic                        lz_blank;
  logic                        bad_code;

  // Load / pending / active. Accept only happens with pending empty and the
  // transfer only with pending full, so the two never collide.
  always_comb begin
    accept      = ld.load_valid && load_ready_q;
    active_d    = active_q;
    pending_d   = pending_q;
    pend_full_d = pend_full_q;
    if (frame_wrap && pend_full_q) begin
      active_d    = pending_q;
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pending_d   = ld.load_data;
      pend_full_d = 1'b1;
    end
    load_ready_d = ~pend_full_d;
  end

  // Digit selection and blanking for the current index.
  always_comb begin
    active_ext               = '0;
    active_ext[DATA_W-1:0]   = active_q;
    cur_dig                  = digit_of(active_ext, int'(idx));
    // All digits from the top down to the current index are zero.
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx) && digit_of(active_ext, j) != '0) upper_zero = 1'b0;
    end
    // Digit 0 is never suppressed so an all-zero value still shows "0".
    lz_blank = lz_en && (idx != '0) && upper_zero;
    bad_code = (cur_dig > BCD_LIM);
  end

  // Output registers; bcd_out holds its last code through the guard window.
  always_comb begin
    digit_en_d   = '0;
    bcd_d        = bcd_q;
    seg_blank_d  = 1'b1;
    frame_done_d = frame_wrap;
    if (!in_guard) begin
      digit_en_d[idx] = 1'b1;
      bcd_d           = bad_code ? '0 : cur_dig;
      seg_blank_d     = bad_code || lz_blank;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q     <= '0;
      pending_q    <= '0;
      pend_full_q  <= 1'b0;
      load_ready_q <= 1'b1;
      bcd_q        <= '0;
      digit_en_q   <= '0;
      seg_blank_q  <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_full_q  <= pend_full_d;
      load_ready_q <= load_ready_d;
      bcd_q        <= bcd_d;
      digit_en_q   <= digit_en_d;
      seg_blank_q  <= seg_blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ld.load_ready = load_ready_q;
  assign bcd_out       = bcd_q;
  assign digit_en      = digit_en_q;
  assign seg_blank     = seg_blank_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2: a slot is 8 cycles (2 guard + 6 drive), a frame 32.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lz_en = 1'b0;
  logic [3:0] bcd_out;
  logic [3:0] digit_en;
  logic       seg_blank;
  logic       frame_done;

  display_scan_ctrl_if #(.NUM_DIGITS(4)) ld ();

  display_scan_ctrl #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .lz_en     (lz_en),
    .bcd_out   (bcd_out),
    .digit_en  (digit_en),
    .seg_blank (seg_blank),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          k        = 0;   // rising edges since reset release
  logic        hs;
  logic [15:0] q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: handshake decided on the stable pre-edge values, sampling at
  // the following falling edge, and the producer presents queued values.
  task automatic tick();
    hs = ld.load_valid && ld.load_ready;
    @(posedge clk);
    k++;
    @(negedge clk);
    if (hs) ld.load_valid = 1'b0;
    if (!ld.load_valid && q.size() > 0) begin
      ld.load_data  = q.pop_front();
      ld.load_valid = 1'b1;
    end
  endtask

  task automatic push(input logic [15:0] v);
    q.push_back(v);
    if (!ld.load_valid) begin
      ld.load_data  = q.pop_front();
      ld.load_valid = 1'b1;
    end
  endtask

  // Expected digit_en after the t-th edge of a frame-aligned run.
  function automatic logic [3:0] exp_en(input int t);
    int pos;
    int slot;
    pos  = (t - 1) % 8;
    slot = ((t - 1) / 8) % 4;
    return (pos >= 2) ? 4'(1 << slot) : 4'b0000;
  endfunction

  // One full frame; eb holds the hand-written expected code per digit slot
  // and eblank the expected seg_blank per digit during drive.
  task automatic frame_check(input logic [15:0] eb, input logic [3:0] eblank,
                             input int rdy_at, input logic rdy_exp, input string tag);
    for (int t = 1; t <= 32; t++) begin
      int pos;
      int slot;
      tick();
      pos  = (t - 1) % 8;
      slot = (t - 1) / 8;
      chk({tag, "/digit_en"}, digit_en, exp_en(t));
      chk({tag, "/frame_done"}, frame_done, (t == 32));
      if (pos >= 2) begin
        chk({tag, "/bcd_out"}, bcd_out, eb[4*slot +: 4]);
        chk({tag, "/seg_blank"}, seg_blank, eblank[slot]);
      end else begin
        chk({tag, "/guard_blank"}, seg_blank, 1'b1);
      end
      if (t == rdy_at) chk({tag, "/load_ready"}, ld.load_ready, rdy_exp);
    end
  endtask

  initial begin
    ld.load_valid = 1'b0;
    ld.load_data  = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst/digit_en", digit_en, 4'b0000);
    chk("rst/bcd_out", bcd_out, 4'h0);
    chk("rst/seg_blank", seg_blank, 1'b1);
    chk("rst/frame_done", frame_done, 1'b0);
    chk("rst/load_ready", ld.load_ready, 1'b1);
    rst = 1'b0;
    k   = 0;

    // 40 idle cycles: scan order, 6-on/2-off, frame_done every 32
    repeat (40) begin
      tick();
      chk("idle/digit_en", digit_en, exp_en(k));
      chk("idle/frame_done", frame_done, (k % 32 == 0));
      chk("idle/seg_blank", seg_blank, ((k - 1) % 8 < 2));
      chk("idle/bcd_out", bcd_out, 4'h0);
    end

    // Load 0x1234 mid-frame; current frame keeps showing zeros
    push(16'h1234);
    while (k < 64) begin
      tick();
      chk("mid/digit_en", digit_en, exp_en(k));
      if ((k - 1) % 8 >= 2) chk("mid/bcd_out", bcd_out, 4'h0);
      if (k == 41 || k == 63) chk("mid/load_ready_low", ld.load_ready, 1'b0);
      if (k == 64) begin
        chk("mid/load_ready_high", ld.load_ready, 1'b1);
        chk("mid/frame_done", frame_done, 1'b1);
      end
    end
    frame_check(16'h1234, 4'b0000, 0, 1'b0, "f1234");

    // Leading-zero blanking
    lz_en = 1'b1;
    push(16'h0075);
    frame_check(16'h1234, 4'b0000, 1, 1'b0, "f1234b");
    push(16'h0000);
    frame_check(16'h0075, 4'b1100, 1, 1'b0, "f0075");

    // Non-BCD digit blanks with code 0
    push(16'h9A31);
    frame_check(16'h0000, 4'b1110, 31, 1'b0, "f0000");

    // Back-to-back loads: second one stalls until the boundary
    push(16'h1111);
    push(16'h2222);
    frame_check(16'h9031, 4'b0100, 2, 1'b0, "f9a31");
    frame_check(16'h1111, 4'b0000, 1, 1'b0, "f1111");
    frame_check(16'h2222, 4'b0000, 32, 1'b1, "f2222");

    // Reset during drive of digit 2 with a pending value held
    push(16'h3333);
    repeat (22) tick();
    chk("pre_rst/load_ready", ld.load_ready, 1'b0);
    chk("pre_rst/digit_en", digit_en, 4'b0100);
    chk("pre_rst/bcd_out", bcd_out, 4'h2);
    rst = 1'b1;
    #1;
    chk("async_rst/digit_en", digit_en, 4'b0000);
    chk("async_rst/seg_blank", seg_blank, 1'b1);
    chk("async_rst/load_ready", ld.load_ready, 1'b1);
    chk("async_rst/bcd_out", bcd_out, 4'h0);
    chk("async_rst/frame_done", frame_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    k   = 0;
    // Active value is 0 and pending was discarded: zeros every frame
    frame_check(16'h0000, 4'b1110, 1, 1'b1, "post_rst");
    frame_check(16'h0000, 4'b1110, 32, 1'b1, "post_rst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed scan controller for the fountain's multi-digit 7-segment display.
- Feeds a single shared BCD-to-7-segment decoder with one digit at a time, via a 4-bit D C B A bus, and drives the one-hot digit-enable lines.
- Accepts new display values through a valid/ready load port and applies them only at frame boundaries, so a frame never shows a mix of old and new digits.
- Handles blanking, leading-zero suppression and non-BCD codes, which the decoder does not define.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits; digit 0 is least significant.
- REFRESH_DIV, 50000: clock cycles per digit slot.
- BLANK_CYCLES, 64: anti-ghosting guard cycles at the start of each slot; must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  new display value offered.
- load_ready  out  1  pending slot is empty; a load is accepted when load_valid && load_ready.
- load_data  in  4*NUM_DIGITS  packed BCD; digit i occupies bits [4i+3:4i].
- lz_en  in  1  leading-zero blanking enable; sampled every cycle.
- bcd_out  out  4  digit code to the decoder, {D,C,B,A} = bcd_out[3:0].
- digit_en  out  NUM_DIGITS  one-hot active-high digit select; all zero during guard.
- seg_blank  out  1  forces the decoder segments off.
- frame_done  out  1  one-cycle pulse when the last slot of a frame ends.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All outputs are registered.
- Reset values: digit_en=0, bcd_out=0, seg_blank=1, frame_done=0, load_ready=1; active register=0, pending empty, slot counter=0, digit index=0, state=GUARD.
- Slot counter: counts 0..REFRESH_DIV-1 and wraps to 0. On wrap, the digit index increments modulo NUM_DIGITS.
- State GUARD (counter < BLANK_CYCLES): digit_en=0 and seg_blank=1; bcd_out holds its last value.
- State DRIVE (counter >= BLANK_CYCLES):
  - digit_en is one-hot on the current index.
  - bcd_out = active digit[index].
  - seg_blank is set per the blanking rules below.
- Output timing: registered outputs reflect the state one cycle after the counter value that selects it. digit_en is therefore high for exactly REFRESH_DIV-BLANK_CYCLES consecutive cycles per slot and low for BLANK_CYCLES.
- Transitions: GUARD goes to DRIVE at counter==BLANK_CYCLES-1 to BLANK_CYCLES. DRIVE goes to GUARD on wrap. There are no other states.
- Blanking rules:
  - A digit code greater than 9 gives seg_blank=1 and bcd_out=0. digit_en still cycles normally.
  - Leading-zero blanking: when lz_en=1 and digits NUM_DIGITS-1 down to i are all zero, seg_blank=1 for digit i.
  - Digit 0 is never leading-zero blanked, so all zeros shows a single "0".
- Load handshake:
  - An accepted load writes the pending register; load_ready falls the next cycle.
  - Frame boundary is the wrap of the slot at index NUM_DIGITS-1. At the boundary, if pending is full, pending moves to active and pending clears; load_ready rises the next cycle.
  - The new active value is used from digit 0 of the following frame.
  - A load accepted in the same cycle as a boundary (pending was empty) lands in pending and is applied at the next boundary.
  - With load_ready low, load_valid is ignored; data is not lost because the producer must hold it.
- frame_done: asserted in the cycle after the boundary wrap, independent of the load logic.
- Reset mid-frame: returns immediately to reset values and discards pending data. Scanning restarts at digit 0 in GUARD.
- Width rules:
  - Counter width = clog2(REFRESH_DIV).
  - Index width = clog2(NUM_DIGITS), minimum 1.
  - Index wrap is explicit compare-to-NUM_DIGITS-1, not natural overflow.

Decomposition:
- Shared package display_pkg holds:
  - BCD_MAX=9 and BCD_W=4;
  - the GUARD/DRIVE state enum;
  - the function digit_of(data, i) for slicing packed BCD.
- One natural sub-module, scan_timer: slot counter plus digit index, producing slot_wrap, frame_wrap and in_guard.
- The top level holds the load/pending/active registers, blanking logic and output registers.
- The existing decoder is instantiated outside this block.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset, then 40 idle cycles:
  - digit_en sequence 0001, 0010, 0100, 1000 repeats;
  - each enable is high 6 cycles with 2 zero cycles between;
  - frame_done pulses once every 32 cycles.
- Load 0x1234 mid-frame:
  - load_ready drops next cycle;
  - the current frame still shows 0,0,0,0;
  - the next frame shows bcd_out 4,3,2,1 on digit_en 0001..1000;
  - load_ready returns high after the boundary.
- Load 0x0075 with lz_en=1: digits 3 and 2 have seg_blank=1, digits 1 and 0 show 7 and 5. Load 0x0000 with lz_en=1: only digit 0 unblanked, showing 0.
- Load 0x9A31: the digit-2 slot has seg_blank=1 and bcd_out=0; other digits show 1, 3, 9; scan timing is unchanged.
- Two back-to-back loads 0x1111 then 0x2222 before a boundary: the second is stalled (load_ready=0). After the boundary 1111 is displayed, then 2222 is accepted and appears one frame later.
- Assert rst during the DRIVE of digit 2: digit_en=0 and seg_blank=1 asynchronously; after release, scan restarts at digit 0 with the active value 0 and pending cleared.
